// File: rtl/seg7_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_pkg                                                                   |
// | Segment patterns, scan FSM states and helpers for the seven-segment monitor|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package seg7_pkg;

  // Lit-segment masks, bit 0 = a ... bit 6 = g
  localparam logic [6:0] c_lit_0 = 7'b0111111;
  localparam logic [6:0] c_lit_1 = 7'b0000110;
  localparam logic [6:0] c_lit_2 = 7'b1011011;
  localparam logic [6:0] c_lit_3 = 7'b1001111;
  localparam logic [6:0] c_lit_4 = 7'b1100110;
  localparam logic [6:0] c_lit_5 = 7'b1101101;
  localparam logic [6:0] c_lit_6 = 7'b1111101;
  localparam logic [6:0] c_lit_7 = 7'b0000111;
  localparam logic [6:0] c_lit_8 = 7'b1111111;
  localparam logic [6:0] c_lit_9 = 7'b1101111;

  localparam logic [3:0] c_max_hi_digit = 4'd5;

  typedef enum logic [1:0] {
    WAIT_SEL = 2'd0,
    SETTLE   = 2'd1,
    HOLD     = 2'd2
  } scan_state_t;

  function automatic logic [5:0] bcd_pair_to_bin(input logic [3:0] hi, input logic [3:0] lo);
    logic [5:0] w_h;
    w_h = {2'b00, hi};
    return (w_h << 3) + (w_h << 1) + {2'b00, lo};
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_pattern_decode                                                        |
// | Active-low seven-segment pattern to BCD, flags patterns that are no digit. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg7in,
  output logic       legal,
  output logic [3:0] bcd
);

  logic [6:0] w_lit;
  assign w_lit = ~seg7in;

  always_comb begin
    legal = 1'b1;
    bcd   = 4'd0;
    case (w_lit)
      c_lit_0: bcd = 4'd0;
      c_lit_1: bcd = 4'd1;
      c_lit_2: bcd = 4'd2;
      c_lit_3: bcd = 4'd3;
      c_lit_4: bcd = 4'd4;
      c_lit_5: bcd = 4'd5;
      c_lit_6: bcd = 4'd6;
      c_lit_7: bcd = 4'd7;
      c_lit_8: bcd = 4'd8;
      c_lit_9: bcd = 4'd9;
      default: legal = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_scan_decoder                                                          |
// | Settles and decodes a scanned two-digit display back to a seconds value.   |
// | Optional SEG7_DEC_STATS_EN adds err_count / frame_count statistics.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
)
(
  input  logic       clock_input,
  input  logic       reset,
  input  logic [7:0] AN,
  input  logic [6:0] seg7in,
  output logic [3:0] digit_lo,
  output logic [3:0] digit_hi,
  output logic [5:0] sec_value,
  output logic       valid,
  output logic       frame_done,
  output logic       seg_err,
  output logic       an_err
`ifdef SEG7_DEC_STATS_EN
  ,
  output logic [7:0]  err_count,
  output logic [15:0] frame_count
`endif
);

  localparam logic [7:0] c_settle = 8'(SETTLE_CYCLES);

  scan_state_t r_state;
  scan_state_t w_next_state;

  logic [7:0] r_count;
  logic [7:0] w_count_next;
  logic [1:0] r_an_prev;
  logic [6:0] r_seg_prev;
  logic       w_start;
  logic       w_incr;
  logic       w_capture;

  logic [3:0] r_digit_lo;
  logic [3:0] r_digit_hi;
  logic [5:0] r_sec_value;
  logic       r_valid;
  logic       r_frame_done;
  logic       r_seg_err;
  logic       r_an_err;
  logic       r_got_lo;
  logic       r_got_hi;
  logic       r_pend_seg;
  logic       r_pend_an;

  logic       w_legal;
  logic [3:0] w_bcd;
  logic       w_unused_an;

  assign w_unused_an = &{1'b0, AN[7:2]};

  logic w_sel_any;
  logic w_sel_both;
  logic w_same;
  logic w_an_change;
  logic w_frame_ready;

  assign w_sel_any     = (AN[1:0] != 2'b11);
  assign w_sel_both    = (AN[1:0] == 2'b00);
  assign w_same        = ({AN[1:0], seg7in} == {r_an_prev, r_seg_prev});
  assign w_an_change   = (AN[1:0] != r_an_prev);
  assign w_frame_ready = r_got_lo & r_got_hi;

  seg7_pattern_decode u_decode (
    .seg7in (seg7in),
    .legal  (w_legal),
    .bcd    (w_bcd)
  );

  always_ff @(posedge clock_input or posedge reset) begin
    if (reset) begin
      r_state <= WAIT_SEL;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      WAIT_SEL: begin
        if (w_capture)    w_next_state = HOLD;
        else if (w_start) w_next_state = SETTLE;
      end
      SETTLE: begin
        if (w_capture)              w_next_state = HOLD;
        else if (w_start || w_incr) w_next_state = SETTLE;
        else                        w_next_state = WAIT_SEL;
      end
      HOLD: begin
        if (w_capture)        w_next_state = HOLD;
        else if (w_start)     w_next_state = SETTLE;
        else if (w_an_change) w_next_state = WAIT_SEL;
      end
      default: w_next_state = WAIT_SEL;
    endcase
  end

  // A capture can fire on the very cycle settling starts when SETTLE_CYCLES is 1
  always_comb begin
    w_start = 1'b0;
    w_incr  = 1'b0;
    case (r_state)
      WAIT_SEL: w_start = w_sel_any;
      SETTLE: begin
        if (w_same) w_incr  = 1'b1;
        else        w_start = w_sel_any;
      end
      HOLD:     w_start = w_an_change & w_sel_any;
      default:  w_start = 1'b0;
    endcase
    if (w_start)     w_count_next = 8'd1;
    else if (w_incr) w_count_next = r_count + 8'd1;
    else             w_count_next = r_count;
    w_capture = (w_start | w_incr) && (w_count_next == c_settle);
  end

  always_ff @(posedge clock_input or posedge reset) begin
    if (reset) begin
      r_count    <= 8'd0;
      r_an_prev  <= 2'b11;
      r_seg_prev <= 7'h7F;
    end else begin
      r_count    <= w_count_next;
      r_an_prev  <= AN[1:0];
      r_seg_prev <= seg7in;
    end
  end

  // Errors and frame results land one edge after the capture that caused them
  always_ff @(posedge clock_input or posedge reset) begin
    if (reset) begin
      r_digit_lo   <= 4'd0;
      r_digit_hi   <= 4'd0;
      r_sec_value  <= 6'd0;
      r_valid      <= 1'b0;
      r_frame_done <= 1'b0;
      r_seg_err    <= 1'b0;
      r_an_err     <= 1'b0;
      r_got_lo     <= 1'b0;
      r_got_hi     <= 1'b0;
      r_pend_seg   <= 1'b0;
      r_pend_an    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_seg_err    <= r_pend_seg | (w_frame_ready && (r_digit_hi > c_max_hi_digit));
      r_an_err     <= r_pend_an;
      r_pend_seg   <= 1'b0;
      r_pend_an    <= 1'b0;
      if (w_frame_ready) begin
        r_got_lo <= 1'b0;
        r_got_hi <= 1'b0;
        if (r_digit_hi <= c_max_hi_digit) begin
          r_sec_value  <= bcd_pair_to_bin(r_digit_hi, r_digit_lo);
          r_valid      <= 1'b1;
          r_frame_done <= 1'b1;
        end
      end
      if (w_capture) begin
        if (w_sel_both) begin
          r_pend_an <= 1'b1;
          r_got_lo  <= 1'b0;
          r_got_hi  <= 1'b0;
        end else if (!w_legal) begin
          r_pend_seg <= 1'b1;
          r_got_lo   <= 1'b0;
          r_got_hi   <= 1'b0;
        end else if (!AN[0]) begin
          r_digit_lo <= w_bcd;
          r_got_lo   <= 1'b1;
        end else begin
          r_digit_hi <= w_bcd;
          r_got_hi   <= 1'b1;
        end
      end
    end
  end

  assign digit_lo   = r_digit_lo;
  assign digit_hi   = r_digit_hi;
  assign sec_value  = r_sec_value;
  assign valid      = r_valid;
  assign frame_done = r_frame_done;
  assign seg_err    = r_seg_err;
  assign an_err     = r_an_err;

`ifdef SEG7_DEC_STATS_EN
  logic [7:0]  r_err_count;
  logic [15:0] r_frame_count;

  always_ff @(posedge clock_input or posedge reset) begin
    if (reset) begin
      r_err_count   <= 8'd0;
      r_frame_count <= 16'd0;
    end else begin
      if ((r_seg_err | r_an_err) && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
      if (r_frame_done) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  assign err_count   = r_err_count;
  assign frame_count = r_frame_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_seg7_scan_decoder                                                       |
// | Directed vector table plus randomized scan traffic against a history model.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_seg7_scan_decoder;

  localparam int S = 4;

  logic       clock_input = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] AN = 8'hFF;
  logic [6:0] seg7in = 7'h7F;
  logic [3:0] digit_lo;
  logic [3:0] digit_hi;
  logic [5:0] sec_value;
  logic       valid;
  logic       frame_done;
  logic       seg_err;
  logic       an_err;
`ifdef SEG7_DEC_STATS_EN
  logic [7:0]  err_count;
  logic [15:0] frame_count;
`endif

  int total = 0;
  int bad = 0;

  always #5 clock_input = ~clock_input;

  seg7_scan_decoder #(.SETTLE_CYCLES(S)) dut (
    .clock_input (clock_input),
    .reset       (reset),
    .AN          (AN),
    .seg7in      (seg7in),
    .digit_lo    (digit_lo),
    .digit_hi    (digit_hi),
    .sec_value   (sec_value),
    .valid       (valid),
    .frame_done  (frame_done),
    .seg_err     (seg_err),
    .an_err      (an_err)
`ifdef SEG7_DEC_STATS_EN
    ,
    .err_count   (err_count),
    .frame_count (frame_count)
`endif
  );

  string dstr[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                      "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  // Active-low bus value that lights exactly the named segments
  function automatic logic [6:0] pat(input string s);
    logic [6:0] m;
    m = 7'd0;
    for (int i = 0; i < s.len(); i++) m[s.getc(i) - 8'h61] = 1'b1;
    return ~m;
  endfunction

  function automatic int ref_decode(input logic [6:0] seg);
    for (int d = 0; d < 10; d++) if (pat(dstr[d]) == seg) return d;
    return -1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: a digit is taken when the last S samples agree, a select is
  // active, and nothing has been taken yet since AN[1:0] last changed.
  int         m_lo = 0, m_hi = 0, m_sec = 0;
  bit         m_valid = 0, m_fd = 0, m_se = 0, m_ae = 0;
  bit         got_lo = 0, got_hi = 0, pend_se = 0, pend_ae = 0;
  bit         run_taken = 0, have_last = 0;
  logic [1:0] last_an = 2'b11;
  logic [8:0] hist[$];

  always @(posedge clock_input or posedge reset) begin
    if (reset) begin
      m_lo = 0; m_hi = 0; m_sec = 0;
      m_valid = 0; m_fd = 0; m_se = 0; m_ae = 0;
      got_lo = 0; got_hi = 0; pend_se = 0; pend_ae = 0;
      run_taken = 0; have_last = 0;
      hist.delete();
    end else begin
      bit all_same;
      int d;
      m_fd = 0;
      m_se = pend_se;
      m_ae = pend_ae;
      pend_se = 0;
      pend_ae = 0;
      if (got_lo && got_hi) begin
        if (m_hi <= 5) begin
          m_sec = m_hi * 10 + m_lo;
          m_valid = 1;
          m_fd = 1;
        end else begin
          m_se = 1;
        end
        got_lo = 0;
        got_hi = 0;
      end
      if (!have_last || AN[1:0] != last_an) run_taken = 0;
      last_an = AN[1:0];
      have_last = 1;
      hist.push_back({AN[1:0], seg7in});
      if (hist.size() > S) void'(hist.pop_front());
      all_same = (hist.size() == S);
      foreach (hist[i]) if (hist[i] != hist[0]) all_same = 0;
      if (all_same && !run_taken && AN[1:0] != 2'b11) begin
        run_taken = 1;
        if (AN[1:0] == 2'b00) begin
          pend_ae = 1; got_lo = 0; got_hi = 0;
        end else begin
          d = ref_decode(seg7in);
          if (d < 0) begin
            pend_se = 1; got_lo = 0; got_hi = 0;
          end else if (!AN[0]) begin
            m_lo = d; got_lo = 1;
          end else begin
            m_hi = d; got_hi = 1;
          end
        end
      end
    end
  end

  task automatic model_check();
    chk("digit_lo", digit_lo, m_lo);
    chk("digit_hi", digit_hi, m_hi);
    chk("sec_value", sec_value, m_sec);
    chk("valid", valid, m_valid);
    chk("frame_done", frame_done, m_fd);
    chk("seg_err", seg_err, m_se);
    chk("an_err", an_err, m_ae);
  endtask

  // Called at a negedge; applies inputs for n cycles, checking every cycle
  task automatic drive(input logic [7:0] an, input logic [6:0] seg, input int n,
                       output int fds, output int ses, output int aes);
    AN = an;
    seg7in = seg;
    fds = 0; ses = 0; aes = 0;
    repeat (n) begin
      @(negedge clock_input);
      model_check();
      fds += int'(frame_done);
      ses += int'(seg_err);
      aes += int'(an_err);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " digit_lo"}, digit_lo, 0);
    chk({tag, " digit_hi"}, digit_hi, 0);
    chk({tag, " sec_value"}, sec_value, 0);
    chk({tag, " valid"}, valid, 0);
    chk({tag, " frame_done"}, frame_done, 0);
    chk({tag, " seg_err"}, seg_err, 0);
    chk({tag, " an_err"}, an_err, 0);
  endtask

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    int         cycles;
    int         lo, hi, sec;
    int         vld;
    int         frames, serrs, aerrs;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int fds, ses, aes;

    vecs[0]  = '{8'hFE, pat("abc"),     10, 7, 0,  0, 0, 0, 0, 0};
    vecs[1]  = '{8'hFD, pat("bcfg"),    10, 7, 4, 47, 1, 1, 0, 0};
    vecs[2]  = '{8'hFE, pat("abcdg"),    3, 7, 4, 47, 1, 0, 0, 0};
    vecs[3]  = '{8'hFE, pat("abcdefg"),  4, 8, 4, 47, 1, 0, 0, 0};
    vecs[4]  = '{8'hFF, pat("abcdefg"),  3, 8, 4, 47, 1, 0, 0, 0};
    vecs[5]  = '{8'hFE, pat("abcdef"),  10, 0, 4, 47, 1, 0, 0, 0};
    vecs[6]  = '{8'hFD, pat("acdefg"),  10, 0, 6, 47, 1, 0, 1, 0};
    vecs[7]  = '{8'hFE, pat("abcd"),    10, 0, 6, 47, 1, 0, 1, 0};
    vecs[8]  = '{8'hFC, pat("abcdefg"),  6, 0, 6, 47, 1, 0, 0, 1};
    vecs[9]  = '{8'hFE, pat("abcdfg"),  10, 9, 6, 47, 1, 0, 0, 0};
    vecs[10] = '{8'hFD, pat("acdfg"),   10, 9, 5, 59, 1, 1, 0, 0};
    vecs[11] = '{8'hFF, pat("abcdefg"),  5, 9, 5, 59, 1, 0, 0, 0};

    #1 reset = 1'b1;
    repeat (2) @(negedge clock_input);
    check_all_zero("reset");
    reset = 1'b0;

    for (int v = 0; v < 12; v++) begin
      drive(vecs[v].an, vecs[v].seg, vecs[v].cycles, fds, ses, aes);
      chk($sformatf("vec%0d digit_lo", v), digit_lo, vecs[v].lo);
      chk($sformatf("vec%0d digit_hi", v), digit_hi, vecs[v].hi);
      chk($sformatf("vec%0d sec_value", v), sec_value, vecs[v].sec);
      chk($sformatf("vec%0d valid", v), valid, vecs[v].vld);
      chk($sformatf("vec%0d frame_done pulses", v), fds, vecs[v].frames);
      chk($sformatf("vec%0d seg_err pulses", v), ses, vecs[v].serrs);
      chk($sformatf("vec%0d an_err pulses", v), aes, vecs[v].aerrs);
    end

    // Reset after the lower digit: a later upper-only capture completes nothing
    drive(8'hFE, pat("bc"), 10, fds, ses, aes);
    chk("pre-reset digit_lo", digit_lo, 1);
    reset = 1'b1;
    #1 check_all_zero("mid-frame reset");
    @(negedge clock_input);
    reset = 1'b0;
    drive(8'hFD, pat("abdeg"), 10, fds, ses, aes);
    chk("post-reset digit_hi", digit_hi, 2);
    chk("post-reset frame_done pulses", fds, 0);
    chk("post-reset valid", valid, 0);
    chk("post-reset sec_value", sec_value, 0);

    // Reset mid-settle restarts the stability count
    drive(8'hFF, 7'h7F, 2, fds, ses, aes);
    drive(8'hFE, pat("abcdfg"), 2, fds, ses, aes);
    reset = 1'b1;
    @(negedge clock_input);
    reset = 1'b0;
    drive(8'hFE, pat("abcdfg"), 3, fds, ses, aes);
    chk("settle restart no capture", digit_lo, 0);
    drive(8'hFE, pat("abcdfg"), 1, fds, ses, aes);
    chk("settle restart capture", digit_lo, 9);

    for (int i = 0; i < 500; i++) begin
      logic [7:0] an;
      logic [6:0] seg;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: an = 8'hFE;
        4, 5, 6:    an = 8'hFD;
        7:          an = 8'hFC;
        8:          an = 8'hFF;
        default:    an = 8'($urandom);
      endcase
      if ($urandom_range(0, 3) != 0) seg = pat(dstr[$urandom_range(0, 9)]);
      else                           seg = 7'($urandom);
      if ($urandom_range(0, 79) == 0) begin
        reset = 1'b1;
        @(negedge clock_input);
        model_check();
        reset = 1'b0;
      end
      drive(an, seg, $urandom_range(1, 9), fds, ses, aes);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
